// File: rtl/irq_rr_grant.sv
// Request collector and round-robin arbiter feeding an 8-to-3 encoder.
// Latches requests into a pending register and issues one-hot grants under a valid/ack handshake with timeout.
module irq_rr_grant #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] i,
    output logic       en,
    output logic [7:0] pending,
    output logic       timeout
);

    localparam int unsigned N      = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam bit          TO_ON  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [CNT_W-1:0] cnt;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] scan_idx;
    logic [N-1:0]     clear_mask;

    // First pending line scanning upward from ptr, wrapping 7->0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int n = 0; n < N; n++) begin
            scan_idx = IDX_W'(ptr + IDX_W'(n));
            if (!sel_found && pending[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    assign clear_mask = (state == GRANT && ack) ? i : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            cnt     <= '0;
            i       <= '0;
            en      <= 1'b0;
            pending <= '0;
            timeout <= 1'b0;
        end else begin
            // Re-asserted request wins over the ack clear on the same edge.
            pending <= (pending & ~clear_mask) | req;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        i       <= N'(1) << sel_idx;
                        en      <= 1'b1;
                        cnt     <= '0;
                        gnt_idx <= sel_idx;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        i     <= '0;
                        en    <= 1'b0;
                        ptr   <= IDX_W'(gnt_idx + IDX_W'(1));
                        state <= GAP;
                    end else if (TO_ON && cnt == TO_LAST) begin
                        i       <= '0;
                        en      <= 1'b0;
                        timeout <= 1'b1;
                        ptr     <= IDX_W'(gnt_idx + IDX_W'(1));
                        state   <= GAP;
                    end else begin
                        cnt <= CNT_W'(cnt + CNT_W'(1));
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake invariants seen by the encoder.
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        (en ? $onehot(i) : (i == '0)));
    a_stable: assert property (@(posedge clk) disable iff (rst)
        ((en && $past(en) && !$past(rst)) -> (i == $past(i))));
    a_pulse: assert property (@(posedge clk) disable iff (rst)
        (!(timeout && $past(timeout))));

endmodule

// File: tb/tb_irq_rr_grant.sv
// Directed bench for irq_rr_grant with TIMEOUT=4.
module tb_irq_rr_grant;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [7:0] i;
    logic       en;
    logic [7:0] pending;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    irq_rr_grant #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .i       (i),
        .en      (en),
        .pending (pending),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 8-to-3 encoder reference.
    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] y;
        y = 3'd0;
        for (int b = 0; b < 8; b++) if (v[b]) y = 3'(b);
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Advance until en is seen, bounded.
    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (en) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({en, i, pending, timeout} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_state c%0d: en=%b i=%h pend=%h to=%b want all 0", c, en, i, pending, timeout);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({en, i, pending, timeout} !== 18'd0) begin
            n_fail++;
            $display("FAIL idle_state: en=%b i=%h pend=%h to=%b want all 0", en, i, pending, timeout);
        end
    endtask

    task automatic test_single();
        req = 8'h20;
        tick();
        req = '0;
        n_cmp++;
        if (pending !== 8'h20 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend: pend=%h en=%b want 20/0", pending, en);
        end
        tick();
        n_cmp++;
        if (en !== 1'b1 || i !== 8'h20) begin
            n_fail++;
            $display("FAIL single_grant: en=%b i=%h want 1/20", en, i);
        end
        n_cmp++;
        if (enc(i) !== 3'd5) begin
            n_fail++;
            $display("FAIL single_enc: y=%0d want 5", enc(i));
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++;
        if (en !== 1'b0 || i !== 8'h00 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_ack: en=%b i=%h pend=%h want 0/00/00", en, i, pending);
        end
        tick(); tick();
        n_cmp++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: en=%b want 0", en);
        end
    endtask

    task automatic test_rr();
        logic [7:0] exp_q [$];
        bit ok;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            exp_q = '{8'h01, 8'h80};
            req = 8'h81;
            tick();
            req = '0;
            foreach (exp_q[g]) begin
                wait_en(ok);
                n_cmp++;
                if (!ok || i !== exp_q[g]) begin
                    n_fail++;
                    $display("FAIL rr_order p%0d g%0d: en=%b i=%h want %h", pass, g, en, i, exp_q[g]);
                end
                ack = 1'b1;
                tick();
                ack = 1'b0;
            end
        end
        // Held request re-pends the acked line.
        exp_q = '{8'h01, 8'h02, 8'h01};
        req = 8'h03;
        foreach (exp_q[g]) begin
            wait_en(ok);
            n_cmp++;
            if (!ok || i !== exp_q[g]) begin
                n_fail++;
                $display("FAIL rr_hold g%0d: en=%b i=%h want %h", g, en, i, exp_q[g]);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            n_cmp++;
            if (pending !== 8'h03) begin
                n_fail++;
                $display("FAIL rr_setwins g%0d: pend=%h want 03", g, pending);
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        req = 8'h04;
        tick();
        req = '0;
        tick();
        hi = 0;
        while (en && hi < 20) begin
            hi++;
            n_cmp++;
            if (timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_early: timeout=%b at cycle %0d want 0", timeout, hi);
            end
            tick();
        end
        n_cmp++;
        if (hi !== 4) begin
            n_fail++;
            $display("FAIL to_len: en high %0d cycles want 4", hi);
        end
        n_cmp++;
        if (timeout !== 1'b1 || i !== 8'h00 || pending !== 8'h04) begin
            n_fail++;
            $display("FAIL to_pulse: to=%b i=%h pend=%h want 1/00/04", timeout, i, pending);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL to_gap: to=%b en=%b want 0/0", timeout, en);
        end
        tick();
        n_cmp++;
        if (en !== 1'b1 || i !== 8'h04) begin
            n_fail++;
            $display("FAIL to_regrant: en=%b i=%h want 1/04", en, i);
        end
    endtask

    // Runs straight on from test_timeout: first cycle of the re-grant.
    task automatic test_collision();
        tick(); tick(); tick();
        n_cmp++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL col_fourth: en=%b want 1", en);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++;
        if (timeout !== 1'b0 || en !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL col_ackwins: to=%b en=%b pend=%h want 0/0/00", timeout, en, pending);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL col_nopulse: to=%b want 0", timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h10;
        tick(); tick();
        n_cmp++;
        if (en !== 1'b1 || i !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_grant: en=%b i=%h want 1/10", en, i);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (en !== 1'b0 || i !== 8'h00 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: en=%b i=%h pend=%h want 0/00/00", en, i, pending);
        end
        tick();
        n_cmp++;
        if (en !== 1'b0 || pending !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_first: en=%b pend=%h want 0/10", en, pending);
        end
        tick();
        n_cmp++;
        if (en !== 1'b1 || i !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_regrant: en=%b i=%h want 1/10", en, i);
        end
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; ack = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
